// File: rtl/tlblookup_stage_param.sv
// ALU->cache pipeline register with a small fully-associative TLB for memory ops.
// A miss stalls the pipe, requests a page-walk fill and replays the held lookup.
module tlb_entry #(
    parameter int TAG_W = 8,
    parameter int PPN_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             wr,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [PPN_W-1:0] wr_ppn,
    input  logic [TAG_W-1:0] vpn,
    output logic             hit,
    output logic [PPN_W-1:0] ppn
);
    logic             valid;
    logic [TAG_W-1:0] tag;

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid <= 1'b0;
            tag   <= '0;
            ppn   <= '0;
        end else if (flush) begin
            valid <= 1'b0;
        end else if (wr) begin
            valid <= 1'b1;
            tag   <= wr_tag;
            ppn   <= wr_ppn;
        end
    end

    assign hit = valid && (tag == vpn);
endmodule

module tlblookup_stage_param #(
    parameter int DATA_W     = 16,
    parameter int PAGE_BITS  = 8,
    parameter int ENTRIES    = 4,
    parameter int REG_ADDR_W = 3,
    parameter int BP_W       = 2
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable_tlblookup,
    input  logic                        valid_input,
    input  logic                        is_mem_input,
    input  logic [DATA_W-1:0]           alu_result,
    input  logic [REG_ADDR_W-1:0]       destReg_addr_input,
    input  logic                        we_input,
    input  logic [BP_W-1:0]             bp_input,
    input  logic                        fill_valid,
    input  logic [DATA_W-PAGE_BITS-1:0] fill_ppn,
    input  logic                        flush,
    output logic [DATA_W-1:0]           tlblookup_result,
    output logic [REG_ADDR_W-1:0]       destReg_addr_output,
    output logic                        we_output,
    output logic [BP_W-1:0]             bp_output,
    output logic                        valid_output,
    output logic                        tlb_stall,
    output logic                        miss_req,
    output logic [DATA_W-PAGE_BITS-1:0] miss_vpn
);
    localparam int VPN_W = DATA_W - PAGE_BITS;
    localparam int PTR_W = $clog2(ENTRIES);

    typedef enum logic {S_IDLE, S_WAIT} state_t;
    state_t state, next_state;

    logic [VPN_W-1:0]              vpn;
    logic [ENTRIES-1:0]            hit_vec;
    logic [ENTRIES-1:0]            wr_vec;
    logic [ENTRIES-1:0][VPN_W-1:0] ppn_vec;
    logic [VPN_W-1:0]              hit_ppn;
    logic [PTR_W-1:0]              ptr;
    logic                          hit, need_xlate, miss, fill_wr;
    logic [DATA_W-1:0]             xlated;

    assign vpn        = alu_result[DATA_W-1:PAGE_BITS];
    assign need_xlate = valid_input && is_mem_input;
    assign miss       = need_xlate && !hit;
    // Flush beats a simultaneous fill: nothing is written.
    assign fill_wr    = (state == S_WAIT) && fill_valid && !flush;

    genvar i;
    generate
        for (i = 0; i < ENTRIES; i++) begin : g_entry
            assign wr_vec[i] = fill_wr && (ptr == PTR_W'(i));
            tlb_entry #(.TAG_W(VPN_W), .PPN_W(VPN_W)) u_entry (
                .clk    (clk),
                .reset  (reset),
                .flush  (flush),
                .wr     (wr_vec[i]),
                .wr_tag (miss_vpn),
                .wr_ppn (fill_ppn),
                .vpn    (vpn),
                .hit    (hit_vec[i]),
                .ppn    (ppn_vec[i])
            );
        end
    endgenerate

    // Tags are unique, so OR-ing the gated PPNs selects the single hit.
    always_comb begin
        hit_ppn = '0;
        for (int e = 0; e < ENTRIES; e++)
            if (hit_vec[e]) hit_ppn = hit_ppn | ppn_vec[e];
    end

    assign hit    = |hit_vec;
    assign xlated = need_xlate ? {hit_ppn, alu_result[PAGE_BITS-1:0]} : alu_result;

    always_ff @(posedge clk) begin
        if (!reset) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (enable_tlblookup && miss) next_state = S_WAIT;
            S_WAIT: if (flush || fill_valid)      next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        tlb_stall = (state != S_IDLE) || (enable_tlblookup && miss);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            tlblookup_result    <= '0;
            destReg_addr_output <= '0;
            we_output           <= 1'b0;
            bp_output           <= '0;
            valid_output        <= 1'b0;
            miss_req            <= 1'b0;
            miss_vpn            <= '0;
            ptr                 <= '0;
        end else begin
            if (enable_tlblookup) begin
                if (tlb_stall) begin
                    tlblookup_result    <= '0;
                    destReg_addr_output <= '0;
                    we_output           <= 1'b0;
                    bp_output           <= '0;
                    valid_output        <= 1'b0;
                end else begin
                    tlblookup_result    <= xlated;
                    destReg_addr_output <= destReg_addr_input;
                    we_output           <= we_input;
                    bp_output           <= bp_input;
                    valid_output        <= valid_input;
                end
            end
            if (state == S_IDLE && enable_tlblookup && miss) begin
                miss_req <= 1'b1;
                miss_vpn <= vpn;
            end else if (state == S_WAIT && (flush || fill_valid)) begin
                miss_req <= 1'b0;
            end
            if (flush)        ptr <= '0;
            else if (fill_wr) ptr <= ptr + PTR_W'(1);
        end
    end
endmodule
